// File: rtl/serial_byte_receiver.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits LSB-first, stop bit,
// presented on a valid/ready port with registered frame-error and overrun pulses.
module serial_byte_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sIn,
    input  logic             bitEn,
    output logic [WIDTH-1:0] pOut,
    output logic             pValid,
    input  logic             pReady,
    output logic             frameErr,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t nextState;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;

    logic startDet;
    logic shiftEn;
    logic lastBit;
    logic stopSample;
    logic slotFree;
    logic loadWord;
    logic dropOverrun;
    logic badStop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (bitEn && !sIn) nextState = DATA;
            DATA: if (bitEn && lastBit) nextState = STOP;
            STOP: if (bitEn) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        startDet    = (state == IDLE) && bitEn && !sIn;
        shiftEn     = (state == DATA) && bitEn;
        lastBit     = (cnt == CW'(WIDTH - 1));
        stopSample  = (state == STOP) && bitEn;
        // A word accepted this cycle frees the slot for a word landing on the same edge.
        slotFree    = !pValid || pReady;
        loadWord    = stopSample && sIn && slotFree;
        dropOverrun = stopSample && sIn && !slotFree;
        badStop     = stopSample && !sIn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sh       <= '0;
            pOut     <= '0;
            pValid   <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            frameErr <= badStop;
            overrun  <= dropOverrun;

            if (startDet) begin
                cnt <= '0;
            end else if (shiftEn) begin
                sh  <= {sIn, sh[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
            end

            if (loadWord) begin
                pOut   <= sh;
                pValid <= 1'b1;
            end else if (pValid && pReady) begin
                pValid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Framed serial-to-parallel receiver: the receiving end of the single-bit serial line that our shift-register chain drives at `sOut`. Qualified by a per-bit enable, it detects a start bit, collects `WIDTH` data bits LSB-first (the first bit shifted out of the chain becomes bit 0), and checks a stop bit. It then presents the word on a valid/ready parallel port. Framing errors and overruns are flagged with single-cycle pulses.

## Interface
- `WIDTH`, 8, number of data bits per frame and width of `pOut` (legal range 2..16).
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sIn`  input  1  serial line; idle level 1, start bit 0, stop bit 1.
- `bitEn`  input  1  when 1, `sIn` carries a valid bit this cycle; when 0, serial-side state holds.
- `pOut`  output  WIDTH  last accepted word; bit 0 = first data bit received.
- `pValid`  output  1  `pOut` holds an unconsumed word.
- `pReady`  input  1  consumer accepts `pOut` when `pValid && pReady`.
- `frameErr`  output  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  output  1  one-cycle pulse: completed word dropped because the output register was occupied.

## Operation
- FSM states: IDLE, DATA, STOP. Bit counter `cnt`, width $clog2(WIDTH); shift register `sh[WIDTH-1:0]`.
- IDLE: on `bitEn && !sIn`, go to DATA and clear `cnt`. On `bitEn && sIn`, or when `bitEn` is low, stay in IDLE.
- DATA: on `bitEn`, update `sh <= {sIn, sh[WIDTH-1:1]}` (right shift, LSB-first) and increment `cnt`. After the WIDTH-th bit (`cnt == WIDTH-1` at that sample), go to STOP.
- STOP: on `bitEn`, always return to IDLE.
  - If `sIn == 1` (good frame) and the output slot is free, set `pOut <= sh` and `pValid <= 1`. The slot is free if `pValid == 0`, or if `pValid && pReady` in the same cycle.
  - If `sIn == 1` and the output slot is occupied (`pValid && !pReady`): drop the word, pulse `overrun`, and leave `pOut`/`pValid` unchanged.
  - If `sIn == 0`: pulse `frameErr` and drop the word. `pOut`/`pValid` are untouched. No re-synchronisation attempt is made: the next start is searched from IDLE on the following enabled bit.
- Output port: `pValid` clears on `pValid && pReady`, unless a new word is loaded in the same cycle, in which case `pValid` stays 1 and `pOut` takes the new word. `pOut` is stable while `pValid && !pReady`.
- `bitEn` low in any state: FSM, `cnt` and `sh` hold. The output handshake continues independently.
- `frameErr` and `overrun` are registered, never both 1, and are 0 in every cycle that is not the cycle following a stop-bit sample.

## Timing
- Reset: state = IDLE, `cnt` = 0, `sh` = 0, `pOut` = 0, `pValid` = 0, `frameErr` = 0, `overrun` = 0. Reset overrides all other inputs in the same cycle.
- Reset mid-frame discards the partial word and any held `pOut`. The first enabled 0 after reset deasserts is a start bit.
- Minimum frame: WIDTH+2 enabled cycles (start, data, stop). Back-to-back frames are allowed: a start bit may arrive on the enabled cycle right after the stop bit.
- Latency: `pValid` (or `frameErr`/`overrun`) is asserted in the cycle after the edge that samples the stop bit.
- `pValid` deasserts in the cycle after the accepting edge (`pValid && pReady` sampled).
- There is no combinational path from inputs to outputs.

## Test plan
- Reset, then send 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) with `bitEn` = 1 continuously and `pReady` = 0 -> `pValid` = 1 and `pOut` = 0xA5 exactly 1 cycle after the stop sample. Raise `pReady` for one cycle -> `pValid` = 0 on the next cycle.
- Send 0x3C with `bitEn` toggling 1,0,1,0… and random `sIn` values on the disabled cycles -> `pOut` = 0x3C; disabled cycles have no effect.
- Send 0x81 with the stop bit = 0 -> one-cycle `frameErr`, `pValid` stays 0. An immediate good frame with 0x7E -> `pOut` = 0x7E.
- Hold `pReady` = 0, send 0x11 then 0x22 back-to-back -> `pOut` = 0x11, one-cycle `overrun` after the second stop bit. Repeat with `pReady` = 1 asserted on the second stop-sample cycle -> no overrun, `pOut` = 0x22, `pValid` stays 1.
- Assert `rst` after 4 data bits of a frame -> all outputs 0. Send a fresh 0xF0 -> received correctly with no `frameErr`.
- Hold `sIn` = 1 with `bitEn` = 1 for 20 cycles -> FSM stays in IDLE, all outputs remain 0.
